// File: rtl/gshare_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gshare_update_ctrl_if
// Description : Bundle for the gshare update controller. It carries the fetch
//               prediction request, the execute resolution and both PHT RAM
//               ports. The slave modport is the controller's view of the
//               bundle. The master modport is the view of the
//               fetch/execute/RAM environment.
// Revision    : 1.0  initial release
// ============================================================================
interface gshare_update_ctrl_if #(
    parameter int LEN = 8
);
    logic           pred_en;
    logic [14:0]    pred_pc;
    logic           pred_ready;
    logic           pred_taken;
    logic           rslt_en;
    logic           rslt_taken;
    logic           mispredict;
    logic [LEN-1:0] pht_ra_addr;
    logic [1:0]     pht_ra_data;
    logic [LEN-1:0] pht_wb_addr;
    logic [1:0]     pht_wb_rdata;
    logic           pht_we;
    logic [1:0]     pht_wdata;
    logic           err_underflow;

    modport slave (
        input  pred_en, pred_pc, rslt_en, rslt_taken, pht_ra_data, pht_wb_rdata,
        output pred_ready, pred_taken, mispredict, pht_ra_addr, pht_wb_addr,
               pht_we, pht_wdata, err_underflow
    );

    modport master (
        output pred_en, pred_pc, rslt_en, rslt_taken, pht_ra_data, pht_wb_rdata,
        input  pred_ready, pred_taken, mispredict, pht_ra_addr, pht_wb_addr,
               pht_we, pht_wdata, err_underflow
    );
endinterface
`default_nettype wire

// File: rtl/gshare_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gshare_update_ctrl
// Description : Sequences gshare PHT lookups and resolution updates. The
//               module keeps an in-order FIFO of in-flight predictions. It
//               holds speculative and architectural global history and
//               recovers the history on a mispredict. After reset it clears
//               every PHT entry to weakly-not-taken.
// Config      : define GSHARE_BYPASS_EN to forward a same-cycle PHT update
//               to the prediction lookup.
// Revision    : 1.0  initial release
// ============================================================================
module gshare_update_ctrl #(
    parameter int LEN   = 8,
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    gshare_update_ctrl_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LEN-1:0]     clr_cnt_q, clr_cnt_d;
    logic [LEN-1:0]     spec_hist_q, arch_hist_q;
    logic [c_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic               mispredict_q, err_q;
    logic [LEN-1:0]     fifo_idx_q [DEPTH];
    logic               fifo_dir_q [DEPTH];

    logic               w_run, w_full, w_empty, w_pop, w_push, w_mis, w_ready, w_taken;
    logic [LEN-1:0]     w_lookup_idx, w_head_idx;
    logic               w_head_dir;
    logic [1:0]         w_upd_data;
    logic               w_unused;

    // Only the top LEN PC bits index the PHT. Only the MSB of the lookup
    // counter gives the direction.
    assign w_unused = ^{bus.pred_pc[14-LEN:0], bus.pht_ra_data[0]};

    // State and clear-pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clear sweep: write one entry per cycle, then enter RUN after the pointer wraps.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + LEN'(1);
            if (clr_cnt_q == {LEN{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    // Lookup, resolution and PHT port B datapath.
    always_comb begin
        w_run        = (state_q == ST_RUN);
        w_lookup_idx = spec_hist_q ^ bus.pred_pc[14:15-LEN];
        w_full       = (cnt_q == c_CNT_W'(DEPTH));
        w_empty      = (cnt_q == '0);
        w_head_idx   = fifo_idx_q[rd_ptr_q];
        w_head_dir   = fifo_dir_q[rd_ptr_q];
        w_pop        = w_run & bus.rslt_en & ~w_empty;
        w_mis        = w_pop & (bus.rslt_taken != w_head_dir);
        if (bus.rslt_taken) begin
            w_upd_data = (bus.pht_wb_rdata == 2'b11) ? 2'b11 : bus.pht_wb_rdata + 2'd1;
        end else begin
            w_upd_data = (bus.pht_wb_rdata == 2'b00) ? 2'b00 : bus.pht_wb_rdata - 2'd1;
        end
        bus.pht_ra_addr = w_lookup_idx;
        bus.pht_we      = ~w_run | w_pop;
        bus.pht_wb_addr = w_run ? w_head_idx : clr_cnt_q;
        bus.pht_wdata   = w_run ? w_upd_data : 2'b01;
`ifdef GSHARE_BYPASS_EN
        if (w_pop && (w_head_idx == w_lookup_idx)) begin
            w_taken = w_upd_data[1];
        end else begin
            w_taken = bus.pht_ra_data[1];
        end
`else
        w_taken = bus.pht_ra_data[1];
`endif
        // A full FIFO still accepts a push when a correct resolution frees the head this cycle.
        w_ready           = w_run & (~w_full | (w_pop & ~w_mis));
        w_push            = bus.pred_en & w_ready & ~w_mis;
        bus.pred_taken    = w_taken;
        bus.pred_ready    = w_ready;
        bus.mispredict    = mispredict_q;
        bus.err_underflow = err_q;
    end

    // FIFO control, history tracking, mispredict pulse and the sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            spec_hist_q  <= '0;
            arch_hist_q  <= '0;
            mispredict_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mispredict_q <= w_mis;
            if (w_run && bus.rslt_en && w_empty) begin
                err_q <= 1'b1;
            end
            if (w_pop) begin
                arch_hist_q <= {arch_hist_q[LEN-2:0], bus.rslt_taken};
            end
            if (w_mis) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                cnt_q       <= '0;
                spec_hist_q <= {arch_hist_q[LEN-2:0], bus.rslt_taken};
            end else begin
                if (w_push) begin
                    wr_ptr_q    <= wr_ptr_q + c_PTR_W'(1);
                    spec_hist_q <= {spec_hist_q[LEN-2:0], w_taken};
                end
                if (w_pop) begin
                    rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    cnt_q <= cnt_q + c_CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    cnt_q <= cnt_q - c_CNT_W'(1);
                end
            end
        end
    end

    // FIFO payload storage. The valid window is tracked by the pointers, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_idx_q[wr_ptr_q] <= w_lookup_idx;
            fifo_dir_q[wr_ptr_q] <= w_taken;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gshare_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_update_ctrl
// Description : Scoreboard bench for gshare_update_ctrl (LEN=8, DEPTH=4).
//               A queue-based reference model sets the expected outputs for
//               each cycle and the expected PHT writes. A monitor process
//               pops those expectations and compares them with the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gshare_update_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gshare_update_ctrl_if #(.LEN(8)) bus ();

    gshare_update_ctrl #(.LEN(8), .DEPTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PHT RAM environment: asynchronous reads and a synchronous port-B write.
    logic [1:0] mem [256];
    assign bus.pht_ra_data  = mem[bus.pht_ra_addr];
    assign bus.pht_wb_rdata = mem[bus.pht_wb_addr];
    always @(posedge clk) begin
        if (bus.pht_we) mem[bus.pht_wb_addr] <= bus.pht_wdata;
    end

    typedef struct packed { logic [7:0] idx; logic dir; } ent_t;
    typedef struct packed { logic we; logic ready; logic mis; logic err; logic run; logic tk; } cyc_t;
    typedef struct packed { logic [7:0] a; logic [1:0] d; } wr_t;

    cyc_t exp_cyc_q [$];
    wr_t  exp_wr_q  [$];

    // Reference model state
    ent_t       inflight [$];
    logic [1:0] ref_pht [256];
    logic [7:0] ref_spec, ref_arch;
    int         ref_clr;
    logic       ref_run, ref_mis, ref_err;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ref_run = 1'b0; ref_clr = 0; ref_spec = '0; ref_arch = '0;
        ref_mis = 1'b0; ref_err = 1'b0; inflight.delete();
    endtask

    task automatic model(input logic r, input logic pe, input logic [14:0] pc,
                         input logic re, input logic rt);
        logic [7:0] idx, widx, old_arch;
        logic [1:0] wd;
        logic       we, pop, mis, ready, tk, new_err;
        int         c;
        cyc_t       e;
        ent_t       h;
        idx  = ref_spec ^ pc[14:7];
        pop  = ref_run && re && (inflight.size() > 0);
        we   = 1'b0; mis = 1'b0; widx = '0; wd = '0;
        if (!ref_run) begin
            we = 1'b1; widx = 8'(ref_clr); wd = 2'b01;
        end else if (pop) begin
            h    = inflight[0];
            we   = 1'b1;
            widx = h.idx;
            c    = int'(ref_pht[h.idx]);
            c    = rt ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
            wd   = 2'(c);
            mis  = (rt != h.dir);
        end
        tk = (ref_pht[idx] >= 2'b10);
`ifdef GSHARE_BYPASS_EN
        if (ref_run && we && widx == idx) tk = (wd >= 2'b10);
`endif
        ready = ref_run && ((inflight.size() < 4) || (pop && !mis));
        e = '{we: we, ready: ready, mis: ref_mis, err: ref_err, run: ref_run, tk: tk};
        exp_cyc_q.push_back(e);
        if (we) begin
            exp_wr_q.push_back('{a: widx, d: wd});
            ref_pht[widx] = wd;
        end
        new_err = ref_err | (ref_run && re && inflight.size() == 0);
        if (!ref_run) begin
            ref_clr++;
            if (ref_clr == 256) begin ref_clr = 0; ref_run = 1'b1; end
        end else begin
            old_arch = ref_arch;
            if (pop) begin
                void'(inflight.pop_front());
                ref_arch = {ref_arch[6:0], rt};
            end
            if (mis) begin
                inflight.delete();
                ref_spec = {old_arch[6:0], rt};
            end else if (pe && ready) begin
                inflight.push_back('{idx: idx, dir: tk});
                ref_spec = {ref_spec[6:0], tk};
            end
        end
        ref_mis = mis;
        ref_err = new_err;
        if (r) model_reset();
    endtask

    task automatic step(input logic r, input logic pe, input logic [14:0] pc,
                        input logic re, input logic rt);
        @(negedge clk);
        rst            = r;
        bus.pred_en    = pe;
        bus.pred_pc    = pc;
        bus.rslt_en    = re;
        bus.rslt_taken = rt;
        #1;
        model(r, pe, pc, re, rt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
    endtask

    // Monitor: pop the expected response for this cycle and compare it with the DUT outputs.
    cyc_t mon_e;
    wr_t  mon_w;
    always @(negedge clk) begin
        #3;
        if (exp_cyc_q.size() > 0) begin
            mon_e = exp_cyc_q.pop_front();
            chk("pht_we",        16'(bus.pht_we),        16'(mon_e.we));
            chk("pred_ready",    16'(bus.pred_ready),    16'(mon_e.ready));
            chk("mispredict",    16'(bus.mispredict),    16'(mon_e.mis));
            chk("err_underflow", 16'(bus.err_underflow), 16'(mon_e.err));
            if (mon_e.run) chk("pred_taken", 16'(bus.pred_taken), 16'(mon_e.tk));
            if (mon_e.we && exp_wr_q.size() > 0) begin
                mon_w = exp_wr_q.pop_front();
                chk("pht_wb_addr", 16'(bus.pht_wb_addr), 16'(mon_w.a));
                chk("pht_wdata",   16'(bus.pht_wdata),   16'(mon_w.d));
            end
        end
    end

    initial begin
        bus.pred_en = 1'b0; bus.pred_pc = '0; bus.rslt_en = 1'b0; bus.rslt_taken = 1'b0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // Abort the clear sweep at entry 100, then run a full sweep.
        idle(100);
        step(1'b1, 1'b0, 15'h0, 1'b0, 1'b0);
        idle(258);

        // Counter 01 at idx 0x80: predicts not-taken. Two not-taken resolutions saturate the counter at 00.
        step(1'b0, 1'b1, 15'h4000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 15'h4000, 1'b1, 1'b0);
        step(1'b0, 1'b1, 15'h4000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 15'h4000, 1'b1, 1'b0);
        idle(1);

        // Fill the FIFO, offer a fifth push, then push and pop while full.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 15'h4000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 15'h4000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 15'h4000, 1'b1, 1'b0);
        // Three in flight, taken resolution against a not-taken prediction, with a same-cycle push.
        step(1'b0, 1'b1, 15'h1234, 1'b1, 1'b1);
        idle(2);

        // Resolution with an empty FIFO.
        step(1'b0, 1'b0, 15'h0, 1'b1, 1'b1);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'b0, ($urandom_range(0, 9) < 6), (($urandom_range(0, 3) == 0) ? 15'h4000 : 15'($urandom)),
                 ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)));
        end

        // Reset clears the error flag and restarts the sweep. Then exercise the same-index update/lookup case.
        step(1'b1, 1'b0, 15'h0, 1'b0, 1'b0);
        idle(257);
        step(1'b0, 1'b1, 15'h4000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 15'h4000, 1'b1, 1'b1);
        idle(3);

        @(negedge clk);
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
